// File: rtl/sdr_dsp_pkg.sv
// Shared SDR DSP definitions: sign-mode sample mapping and the round/saturate helper.
// Latency: none (types, constants and a combinational function only).
// Backpressure: none; consumers apply these in free-running pipelines.
package sdr_dsp_pkg;

   // Working width for round_sat; wide enough for any product width used here.
   localparam int RS_W = 64;

   // 1-bit comparator stream mapping: bit 0 -> +1, bit 1 -> -1.
   localparam logic SIGN_POS = 1'b0;
   localparam logic SIGN_NEG = 1'b1;

   // Sign-mode synchroniser flops power up / reset to this level.
   localparam logic SYNC_RST_VAL = 1'b1;

   typedef struct packed {
      logic                   sat;  // value was clamped
      logic signed [RS_W-1:0] val;  // rounded, clamped value (sign-extended)
   } rs_t;

   // Round half up by 'shift' bits, then clamp to a signed 'ow'-bit range.
   function automatic rs_t round_sat(input logic signed [RS_W-1:0] p,
                                     input int shift,
                                     input int ow);
      logic signed [RS_W-1:0] r;
      logic signed [RS_W-1:0] hi;
      logic signed [RS_W-1:0] lo;
      rs_t res;
      r = p;
      if (shift > 0)
         r = r + (64'sd1 <<< (shift - 1));
      r  = r >>> shift;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      res.sat = 1'b0;
      res.val = r;
      if (r > hi) begin
         res.val = hi;
         res.sat = 1'b1;
      end else if (r < lo) begin
         res.val = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mixer_round_sat.sv
// One mixer rail: round-half-up by SHIFT then clamp a PW-bit product to OUT_WIDTH.
// Latency: 0 cycles (combinational); the parent registers y/sat.
// Backpressure: none.
// Ports: p (signed product in), y (rounded/clamped value out), sat (y was clamped).
module mixer_round_sat
   import sdr_dsp_pkg::*;
#(
   parameter int PW        = 13,
   parameter int SHIFT     = 0,
   parameter int OUT_WIDTH = 12
) (
   input  logic signed [PW-1:0]        p,
   output logic signed [OUT_WIDTH-1:0] y,
   output logic                        sat
);

   rs_t  rs;
   logic unused_ext;

   always_comb rs = round_sat(RS_W'(p), SHIFT, OUT_WIDTH);

   assign y   = rs.val[OUT_WIDTH-1:0];
   assign sat = rs.sat;
   // After clamping, the upper bits are pure sign extension.
   assign unused_ext = ^rs.val[RS_W-1:OUT_WIDTH];

endmodule

// File: rtl/iq_mixer_pipe.sv
// Quadrature mixer: RF x (cos, sin) with round/saturate, sideband select and sticky overflow.
// Latency: 3 cycles from in_valid to out_valid (plus RF_SYNC on the rf path in sign mode).
// Backpressure: none; free-running pipeline, outputs hold between valid samples.
// Ports: clk, rst (async high); rf_in, in_valid, sin_in, cos_in, conj, sat_clr in;
//        rf_fb (first sync stage), i_out, q_out, out_valid, sat_flag out.
module iq_mixer_pipe
   import sdr_dsp_pkg::*;
#(
   parameter int IN_WIDTH  = 1,
   parameter int LO_WIDTH  = 12,
   parameter int OUT_WIDTH = 12,
   parameter int SHIFT     = 0,
   parameter int RF_SYNC   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [IN_WIDTH-1:0]         rf_in,
   input  logic                        in_valid,
   input  logic signed [LO_WIDTH-1:0]  sin_in,
   input  logic signed [LO_WIDTH-1:0]  cos_in,
   input  logic                        conj,
   input  logic                        sat_clr,
   output logic                        rf_fb,
   output logic signed [OUT_WIDTH-1:0] i_out,
   output logic signed [OUT_WIDTH-1:0] q_out,
   output logic                        out_valid,
   output logic                        sat_flag
);

   // Sign mode needs one extra bit so -(-2^(LO_WIDTH-1)) is representable.
   localparam int PW = (IN_WIDTH == 1) ? LO_WIDTH + 1 : IN_WIDTH + LO_WIDTH;

   logic [IN_WIDTH-1:0]        rf_d;
   logic [IN_WIDTH-1:0]        s1_rf;
   logic signed [LO_WIDTH-1:0] s1_sin, s1_cos;
   logic                       s1_conj, s1_vld;
   logic signed [PW-1:0]       pi_c, pq_raw, pq_c;
   logic signed [PW-1:0]       s2_pi, s2_pq;
   logic                       s2_vld;
   logic signed [OUT_WIDTH-1:0] ri, rq;
   logic                       sat_i, sat_q;

   generate
      if (IN_WIDTH == 1) begin : g_sign
         // sync_q[0] is the first stage; new samples shift in at bit 0.
         logic [RF_SYNC-1:0]   sync_q;
         logic signed [PW-1:0] cos_x, sin_x;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) sync_q <= {RF_SYNC{SYNC_RST_VAL}};
            else     sync_q <= {sync_q[RF_SYNC-2:0], rf_in[0]};
         end

         assign rf_fb = sync_q[0];
         assign rf_d  = sync_q[RF_SYNC-1];

         // +/-LO select; no multiplier.
         assign cos_x  = PW'(s1_cos);
         assign sin_x  = PW'(s1_sin);
         assign pi_c   = (s1_rf[0] == SIGN_NEG) ? -cos_x : cos_x;
         assign pq_raw = (s1_rf[0] == SIGN_NEG) ? -sin_x : sin_x;
      end else begin : g_mult
         assign rf_fb  = 1'b0;
         assign rf_d   = rf_in;
         assign pi_c   = PW'($signed(s1_rf)) * PW'(s1_cos);
         assign pq_raw = PW'($signed(s1_rf)) * PW'(s1_sin);
      end
   endgenerate

   // conj travels with its own sample, so only that sample's Q rail flips.
   assign pq_c = s1_conj ? -pq_raw : pq_raw;

   // S1: capture operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_rf   <= '0;
         s1_sin  <= '0;
         s1_cos  <= '0;
         s1_conj <= 1'b0;
         s1_vld  <= 1'b0;
      end else begin
         s1_rf   <= rf_d;
         s1_sin  <= sin_in;
         s1_cos  <= cos_in;
         s1_conj <= conj;
         s1_vld  <= in_valid;
      end
   end

   // S2: full-precision products.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_pi  <= '0;
         s2_pq  <= '0;
         s2_vld <= 1'b0;
      end else begin
         s2_pi  <= pi_c;
         s2_pq  <= pq_c;
         s2_vld <= s1_vld;
      end
   end

   mixer_round_sat #(.PW(PW), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)) u_rs_i (
      .p   (s2_pi),
      .y   (ri),
      .sat (sat_i)
   );

   mixer_round_sat #(.PW(PW), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)) u_rs_q (
      .p   (s2_pq),
      .y   (rq),
      .sat (sat_q)
   );

   // S3: outputs; data only updates on valid so it holds through gaps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= s2_vld;
         if (s2_vld) begin
            i_out <= ri;
            q_out <= rq;
         end
         // A new clamp outranks a simultaneous clear.
         if (s2_vld && (sat_i || sat_q)) sat_flag <= 1'b1;
         else if (sat_clr)               sat_flag <= 1'b0;
      end
   end

endmodule
